// File: rtl/relu_maxpool2x2_seq.sv
// Streaming 2x2 stride-2 max-pool with fused ReLU on sign-magnitude words.
// Even rows fold pairs into a half-width line buffer; odd rows finish each
// window and load the single-entry output register.
module relu_maxpool2x2_seq #(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8,
  parameter int unsigned COL_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned HalfW = IMG_W / 2;
  localparam int unsigned IdxW  = (HalfW > 1) ? $clog2(HalfW) : 1;
  localparam logic [COL_W-1:0] ColLast = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] RowLast = COL_W'(IMG_H - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [COL_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [31:0]       hold_q, hold_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  // Partial column-pair maxima from the even row; never read before written.
  logic [31:0]       linebuf [2**IdxW];
  logic [IdxW-1:0]   lb_idx;
  logic              lb_we;
  logic [31:0]       lb_wdata;
  logic [31:0]       lb_rdata;

  logic [31:0]       relu_x;
  logic              accept;

  // ReLU'd values are non-negative, so an unsigned compare orders them correctly.
  function automatic logic [31:0] max_u(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

  // Next-state, datapath and handshake decode.
  always_comb begin
    relu_x      = in_data[31] ? 32'd0 : {1'b0, in_data[30:0]};
    lb_idx      = IdxW'(col_q >> 1);
    lb_rdata    = linebuf[lb_idx];
    lb_wdata    = max_u(hold_q, relu_x);
    lb_we       = 1'b0;
    in_ready    = (state_q == StRun) && (!out_valid_q || out_ready);
    accept      = in_valid && in_ready;
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    hold_d      = hold_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    busy        = 1'b0;
    frame_done  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          row_d   = '0;
          col_d   = '0;
        end
      end
      StRun: begin
        busy = 1'b1;
        if (accept) begin
          unique case ({row_q[0], col_q[0]})
            2'b00: hold_d = relu_x;
            2'b01: lb_we  = 1'b1;
            2'b10: hold_d = max_u(lb_rdata, relu_x);
            2'b11: begin
              out_data_d  = max_u(hold_q, relu_x);
              out_valid_d = 1'b1;
            end
            default: ;
          endcase
          if (col_q == ColLast) begin
            col_d = '0;
            if (row_q == RowLast) begin
              row_d   = '0;
              state_d = StDone;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StDone: begin
        // Hold off completion until the final result has been taken.
        if (out_valid_q) begin
          busy = 1'b1;
        end else begin
          frame_done = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Line-buffer write port.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf[lb_idx] <= lb_wdata;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_relu_maxpool2x2_seq.sv
// Self-checking bench for relu_maxpool2x2_seq on a 4x4 frame: directed cases
// plus randomized frames scored against a window-max reference model.
module tb_relu_maxpool2x2_seq;

  localparam int unsigned W = 4;
  localparam int unsigned H = 4;
  localparam int unsigned N = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        busy;
  logic        frame_done;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] px[N];
  int          valid_gap = 0;
  bit          rand_ready = 1'b0;
  bit          stalled = 1'b0;
  logic [31:0] stall_data;

  relu_maxpool2x2_seq #(
    .IMG_W(W),
    .IMG_H(H),
    .COL_W(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] x);
    return x[31] ? 32'd0 : x;
  endfunction

  // Reference: max of the ReLU'd values of each window, raster order.
  task automatic push_expected();
    for (int wy = 0; wy < int'(H / 2); wy++) begin
      for (int wx = 0; wx < int'(W / 2); wx++) begin
        logic [31:0] m;
        m = 32'd0;
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            logic [31:0] v;
            v = relu(px[(2 * wy + dy) * W + 2 * wx + dx]);
            if (v > m) m = v;
          end
        end
        exp_q.push_back(m);
      end
    end
  endtask

  // Output scoreboard, stall stability and completion ordering.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_hold", out_data, stall_data);
      end
      stalled = 1'b0;
      if (out_valid && !out_ready) begin
        stalled    = 1'b1;
        stall_data = out_data;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_out", out_valid, 0);
        else check("out_data", out_data, exp_q.pop_front());
      end
      if (frame_done) check("done_with_pending", 32'(exp_q.size()), 0);
    end else begin
      stalled = 1'b0;
    end
  end

  // Random downstream backpressure when enabled.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = 1'($urandom_range(1));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input logic [31:0] d);
    int t;
    while (valid_gap > 0 && int'($urandom_range(99)) < valid_gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic start_frame();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame_done();
    int t;
    t = 0;
    @(negedge clk);
    while (!frame_done && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("frame_done_seen", frame_done, 1);
    check("queue_empty_at_done", 32'(exp_q.size()), 0);
    check("busy_low_at_done", busy, 0);
    @(negedge clk);
    check("frame_done_one_cycle", frame_done, 0);
    check("busy_after_frame", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame();
    push_expected();
    start_frame();
    for (int i = 0; i < int'(N); i++) send_beat(px[i]);
    wait_frame_done();
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < int'(N); i++) px[i] = 32'(i + 1);
  endtask

  initial begin
    // Reset with in_valid asserted.
    in_valid = 1'b1;
    in_data  = 32'h0000_1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_out_data", out_data, 0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Ramp 1..16 with free-flowing output: 6, 8, 14, 16.
    fill_ramp();
    run_frame();

    // All-negative frame, including negative zero.
    for (int i = 0; i < int'(N); i++) begin
      case (i % 3)
        0:       px[i] = 32'h8000_0000;
        1:       px[i] = 32'hFFFF_FFFF;
        default: px[i] = 32'h8000_0001;
      endcase
    end
    run_frame();

    // Large-magnitude negative must not beat a positive.
    for (int i = 0; i < int'(N); i++) px[i] = 32'd0;
    px[0] = 32'h8000_0005;
    px[1] = 32'h0000_0003;
    px[4] = 32'h7FFF_FFFF;
    px[5] = 32'h0000_0001;
    run_frame();

    // Backpressure on the first result and on the last.
    fill_ramp();
    push_expected();
    out_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 6; i++) send_beat(px[i]);
    @(negedge clk);
    check("bp_out_valid", out_valid, 1);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_data", out_data, 32'd6);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = px[6];
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready_hold", in_ready, 0);
      check("bp_data_hold", out_data, 32'd6);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 6; i < int'(N); i++) send_beat(px[i]);
    out_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("bp_no_early_done", frame_done, 0);
      check("bp_busy_held", busy, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_frame_done();

    // start pulsed mid-frame has no effect.
    fill_ramp();
    push_expected();
    start_frame();
    for (int i = 0; i < int'(N); i++) begin
      if (i == 9) begin
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("mid_start_busy", busy, 1);
        @(posedge clk);
        #1;
      end
      send_beat(px[i]);
    end
    wait_frame_done();

    // Asynchronous reset after 7 beats, then a clean frame.
    fill_ramp();
    push_expected();
    start_frame();
    for (int i = 0; i < 7; i++) send_beat(px[i]);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_frame_done", frame_done, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame();

    // Randomized frames with input gaps and random backpressure.
    valid_gap  = 30;
    rand_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < int'(N); i++) px[i] = {1'($urandom_range(1)), 31'($urandom)};
      run_frame();
    end
    rand_ready = 1'b0;
    valid_gap  = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
